// File: rtl/int_to_float_lzc_pipe.sv
// Two-stage pipelined priority encoder / leading-zero counter for int-to-float normalisation.
// Latency: a word presented with in_valid & in_ready is on the outputs 2 cycles later; 1 word/cycle.
// Backpressure: valid/ready; absorbs 2 words while out_ready=0, and in_ready follows out_ready combinationally.
//
// Ports:
//   clock, reset_n            clock and asynchronous active-low reset
//   in_valid/in_ready/in_data input handshake and word to encode
//   out_valid/out_ready       output handshake
//   out_data                  registered copy of the accepted word
//   out_q                     index of the winning set bit (highest, or lowest when LSB_PRIORITY=1)
//   out_lzc                   zeros before the winning bit (trailing zeros in LSB mode), WIDTH when all-zero
//   out_zero                  accepted word was all zeros
module int_to_float_lzc_pipe #(
  parameter int WIDTH        = 32,
  parameter int GROUP        = 8,
  parameter int LSB_PRIORITY = 0,
  localparam int WIDTHAD     = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [WIDTHAD-1:0] out_q,
  output logic [WIDTHAD:0]   out_lzc,
  output logic               out_zero
);

  localparam int NG = WIDTH / GROUP;
  localparam int GW = $clog2(GROUP);

  // Stage-1 combinational: per-group nonzero flag and local winner index.
  logic [NG-1:0] grp_nz;
  logic [GW-1:0] grp_loc [NG];

  always_comb begin : grp_enc
    logic hit;
    for (int g = 0; g < NG; g++) begin
      hit        = 1'b0;
      grp_loc[g] = '0;
      for (int b = 0; b < GROUP; b++) begin
        if (in_data[g*GROUP + b]) begin
          // Ascending scan: MSB mode keeps overwriting (last set bit wins),
          // LSB mode keeps the first set bit found.
          if (LSB_PRIORITY == 0 || !hit) grp_loc[g] = GW'(b);
          hit = 1'b1;
        end
      end
      grp_nz[g] = hit;
    end
  end

  // Stage-1 registers.
  logic          s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic [NG-1:0] s1_nz;
  logic [GW-1:0] s1_loc [NG];

  // Stage-2 combinational: pick the winning group and form index / count.
  logic [WIDTHAD-1:0] sel_q;
  logic [WIDTHAD:0]   sel_lzc;
  logic               sel_hit;

  always_comb begin
    sel_hit = 1'b0;
    sel_q   = '0;
    for (int g = 0; g < NG; g++) begin
      if (s1_nz[g] && (LSB_PRIORITY == 0 || !sel_hit)) begin
        // Group base is a multiple of GROUP, so this is {group index, local index}.
        sel_q   = WIDTHAD'(g*GROUP + int'(s1_loc[g]));
        sel_hit = 1'b1;
      end
    end
    if (!sel_hit)
      sel_lzc = (WIDTHAD+1)'(WIDTH);
    else if (LSB_PRIORITY != 0)
      sel_lzc = {1'b0, sel_q};
    else
      sel_lzc = (WIDTHAD+1)'(WIDTH-1) - {1'b0, sel_q};
  end

  // Flow control: s1 advances whenever the output slot is free or being drained.
  logic s1_adv;
  logic in_fire;

  assign s1_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s1_adv;
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_q     <= '0;
      out_lzc   <= '0;
      out_zero  <= 1'b0;
    end else begin
      if (in_fire)
        s1_valid <= 1'b1;
      else if (s1_adv)
        s1_valid <= 1'b0;

      if (s1_adv) begin
        out_valid <= s1_valid;
        // Result registers only move on a real word, so bubbles never
        // expose un-reset stage-1 contents.
        if (s1_valid) begin
          out_data <= s1_data;
          out_q    <= sel_q;
          out_lzc  <= sel_lzc;
          out_zero <= !sel_hit;
        end
      end
    end
  end

  // Stage-1 data path is deliberately not reset; s1_valid qualifies it.
  always_ff @(posedge clock) begin
    if (in_fire) begin
      s1_data <= in_data;
      s1_nz   <= grp_nz;
      s1_loc  <= grp_loc;
    end
  end

endmodule
